// File: rtl/xnor_prbs_pkg.sv
// Shared definitions for the XNOR-feedback PRBS generator/checker pair:
// checker FSM encoding, standard tap masks and the feedback function.
package xnor_prbs_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    // XNOR-form tap masks, bit i set means state[i] feeds back
    localparam logic [6:0]  TAPS_PRBS7  = 7'b1100000;                    // x^7  + x^6  + 1
    localparam logic [14:0] TAPS_PRBS15 = 15'b110000000000000;           // x^15 + x^14 + 1
    localparam logic [22:0] TAPS_PRBS23 = 23'b10000100000000000000000;   // x^23 + x^18 + 1

    // Feedback bit: XNOR reduction of the tapped state bits (callers zero-extend)
    function automatic logic prbs_next(input logic [31:0] state, input logic [31:0] taps);
        return ~^(state & taps);
    endfunction

endpackage

// File: rtl/xnor_prbs_checker_if.sv
// Stream-in / status-out bundle of the PRBS checker.
interface xnor_prbs_checker_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 in_valid;
    logic                 in_bit;
    logic                 clr_cnt;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_bit, clr_cnt,
        input  locked, err_pulse, err_count
    );

    modport slave (
        input  in_valid, in_bit, clr_cnt,
        output locked, err_pulse, err_count
    );
endinterface

// File: rtl/xnor_lfsr_core.sv
// XNOR LFSR state register with selectable shift-in source (external bit or
// own prediction); shared by the PRBS generator and checker.
module xnor_lfsr_core
    import xnor_prbs_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_PRBS7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             sel_predict,
    input  logic             in_bit,
    output logic             predict,
    output logic [WIDTH-1:0] state_next
);

    logic [WIDTH-1:0] state_r;
    logic             predict_s;
    logic             sbit_s;
    logic [WIDTH-1:0] state_next_s;

    assign predict_s    = prbs_next(32'(state_r), 32'(TAPS));
    assign sbit_s       = sel_predict ? predict_s : in_bit;
    assign state_next_s = {state_r[WIDTH-2:0], sbit_s};

    // State register: newest bit enters at state[0]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= '0;
        end else if (shift_en) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign predict    = predict_s;
    assign state_next = state_next_s;

endmodule

// File: rtl/xnor_prbs_checker.sv
// Receive-side XNOR PRBS checker: seeds from the stream, verifies a run of
// matches, then flywheels on its own prediction and counts bit errors.
module xnor_prbs_checker
    import xnor_prbs_pkg::*;
#(
    parameter int               WIDTH       = 7,
    parameter logic [WIDTH-1:0] TAPS        = TAPS_PRBS7,
    parameter int               LOCK_COUNT  = 16,
    parameter int               UNLOCK_ERRS = 4,
    parameter int               ERR_CNT_W   = 16
) (
    input logic                clk,
    input logic                rst_n,
    xnor_prbs_checker_if.slave bus
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [FILL_W-1:0]    FILL_MAX   = FILL_W'(WIDTH);
    localparam logic [FILL_W-1:0]    FILL_ONE   = FILL_W'(1);
    localparam logic [MATCH_W-1:0]   LOCK_LAST  = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MATCH_W-1:0]   MATCH_ONE  = MATCH_W'(1);
    localparam logic [MISS_W-1:0]    MISS_LAST  = MISS_W'(UNLOCK_ERRS - 1);
    localparam logic [MISS_W-1:0]    MISS_ONE   = MISS_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE    = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};
    localparam logic [WIDTH-1:0]     LOCKUP_ST  = {WIDTH{1'b1}};

    chk_state_e           fsm_r;
    logic [FILL_W-1:0]    fill_r;
    logic [MATCH_W-1:0]   match_r;
    logic [MISS_W-1:0]    miss_r;
    logic                 locked_r;
    logic                 err_pulse_r;
    logic [ERR_CNT_W-1:0] err_count_r;

    logic                 predict_s;
    logic [WIDTH-1:0]     state_next_s;
    logic                 mismatch_s;
    logic                 count_err_s;
    logic [FILL_W-1:0]    fill_inc_s;

    xnor_lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en    (bus.in_valid),
        .sel_predict (fsm_r == LOCKED),
        .in_bit      (bus.in_bit),
        .predict     (predict_s),
        .state_next  (state_next_s)
    );

    assign mismatch_s  = bus.in_bit ^ predict_s;
    assign count_err_s = bus.in_valid && (fsm_r == LOCKED) && mismatch_s;
    // Fill saturates at WIDTH so a lockup slide in SEED re-tests every new bit
    assign fill_inc_s  = (fill_r == FILL_MAX) ? FILL_MAX : (fill_r + FILL_ONE);

    // Sync FSM, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= SEED;
            fill_r      <= '0;
            match_r     <= '0;
            miss_r      <= '0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            err_count_r <= '0;
        end else begin
            err_pulse_r <= count_err_s;

            // Clear wins over increment, but a coincident error still lands
            if (bus.clr_cnt) begin
                err_count_r <= count_err_s ? ERR_ONE : '0;
            end else if (count_err_s && (err_count_r != ERR_MAX)) begin
                err_count_r <= err_count_r + ERR_ONE;
            end else begin
                err_count_r <= err_count_r;
            end

            if (bus.in_valid) begin
                case (fsm_r)
                    SEED: begin
                        fill_r <= fill_inc_s;
                        if ((fill_inc_s == FILL_MAX) && (state_next_s != LOCKUP_ST)) begin
                            fsm_r   <= VERIFY;
                            match_r <= '0;
                        end else begin
                            fsm_r <= SEED;
                        end
                    end
                    VERIFY: begin
                        if (mismatch_s) begin
                            fsm_r  <= SEED;
                            fill_r <= '0;
                        end else if (match_r == LOCK_LAST) begin
                            fsm_r    <= LOCKED;
                            locked_r <= 1'b1;
                            miss_r   <= '0;
                        end else begin
                            match_r <= match_r + MATCH_ONE;
                        end
                    end
                    LOCKED: begin
                        if (!mismatch_s) begin
                            miss_r <= '0;
                        end else if (miss_r == MISS_LAST) begin
                            fsm_r    <= SEED;
                            fill_r   <= '0;
                            locked_r <= 1'b0;
                            miss_r   <= '0;
                        end else begin
                            miss_r <= miss_r + MISS_ONE;
                        end
                    end
                    default: begin
                        fsm_r    <= SEED;
                        fill_r   <= '0;
                        locked_r <= 1'b0;
                    end
                endcase
            end else begin
                fsm_r <= fsm_r;
            end
        end
    end

    assign bus.locked    = locked_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_xnor_prbs_checker.sv
// Scoreboard bench: directed PRBS7 streams drive two checkers (16-bit and
// 3-bit error counters); expected status per cycle is queued and compared.
module tb_xnor_prbs_checker;

    typedef struct {
        logic lock;
        logic pulse;
        int   cnt_a;
        int   cnt_b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [6:0] gen_s = 7'd0;
    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    string phase = "init";

    xnor_prbs_checker_if #(.ERR_CNT_W(16)) if_a ();
    xnor_prbs_checker_if #(.ERR_CNT_W(3))  if_b ();

    xnor_prbs_checker #(.ERR_CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    xnor_prbs_checker #(.ERR_CNT_W(3))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    always #5 clk = ~clk;

    function automatic int sat7(input int n);
        return (n > 7) ? 7 : n;
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s [%s]: got %0d expected %0d", name, phase, act, exp);
        end
    endfunction

    // Reference XNOR PRBS7 generator, one bit per call
    function automatic logic gen_bit();
        logic b;
        b = ~^(gen_s & 7'b1100000);
        gen_s = {gen_s[5:0], b};
        return b;
    endfunction

    task automatic drive(input logic v, input logic b, input logic c);
        if_a.in_valid = v; if_a.in_bit = b; if_a.clr_cnt = c;
        if_b.in_valid = v; if_b.in_bit = b; if_b.clr_cnt = c;
    endtask

    task automatic send(input logic v, input logic b, input logic c,
                        input logic el, input logic ep, input int n);
        exp_t e;
        @(negedge clk);
        drive(v, b, c);
        e.lock = el; e.pulse = ep; e.cnt_a = n; e.cnt_b = sat7(n);
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_locked_a", int'(if_a.locked),    0);
        chk("rst_pulse_a",  int'(if_a.err_pulse), 0);
        chk("rst_count_a",  int'(if_a.err_count), 0);
        chk("rst_locked_b", int'(if_b.locked),    0);
        chk("rst_pulse_b",  int'(if_b.err_pulse), 0);
        chk("rst_count_b",  int'(if_b.err_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gen_s = 7'd0;
    endtask

    // Monitor: one queued expectation per driven cycle, sampled after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("locked_a", int'(if_a.locked),    int'(e.lock));
                chk("pulse_a",  int'(if_a.err_pulse), int'(e.pulse));
                chk("count_a",  int'(if_a.err_count), e.cnt_a);
                chk("locked_b", int'(if_b.locked),    int'(e.lock));
                chk("pulse_b",  int'(if_b.err_pulse), int'(e.pulse));
                chk("count_b",  int'(if_b.err_count), e.cnt_b);
            end
        end
    end

    initial begin
        logic b;
        logic inv;
        logic lk;
        int n;

        drive(1'b0, 1'b0, 1'b0);

        // Lock from zero, single error at bit 40, 4-bit burst at 61..64, relock at 87
        phase = "lock_err_resync";
        apply_reset();
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            b   = gen_bit();
            inv = (i == 40) || (i >= 61 && i <= 64);
            if (inv) n++;
            lk  = (i >= 23 && i <= 63) || (i >= 87);
            send(1'b1, b ^ inv, 1'b0, lk, inv, n);
        end

        // Gapped stream: garbage on idle cycles, error on valid bit 30
        phase = "gapped";
        apply_reset();
        for (int j = 1; j <= 35; j++) begin
            b = gen_bit();
            send(1'b1, b ^ (j == 30), 1'b0, j >= 23, j == 30, (j >= 30) ? 1 : 0);
            send(1'b0, 1'(j % 2), 1'b0, j >= 23, 1'b0, (j >= 30) ? 1 : 0);
        end

        // All-ones input never leaves SEED
        phase = "all_ones";
        apply_reset();
        for (int i = 1; i <= 100; i++) begin
            send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        end

        // Ten isolated errors (saturate 3-bit), clr with/without error, then reset while locked
        phase = "sat_clr";
        apply_reset();
        n = 0;
        for (int i = 1; i <= 52; i++) begin
            b   = gen_bit();
            inv = ((i >= 30) && (i <= 48) && (i % 2 == 0)) || (i == 50) || (i == 52);
            if (inv) n++;
            if (i == 50) n = 1;
            if (i == 51) n = 0;
            send(1'b1, b ^ inv, (i == 50 || i == 51) ? 1'b1 : 1'b0, i >= 23, inv, n);
        end
        phase = "reset_while_locked";
        apply_reset();

        // Bounded drain of the scoreboard
        phase = "drain";
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
